// File: rtl/ili_window_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_ili9341
//  Description : Shared constants, FSM state type, window tuple and the
//                pixel-count helper for the ILI9341 window writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_ili9341;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // 240 * 320 = 76800 pixels fits in 17 bits
  localparam int PIX_CNT_W = 17;

  // Index of the RAMWR byte, the last of the 11 window bytes
  localparam logic [3:0] WIN_IDX_LAST = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_PIX_REQ = 3'd4,
    ST_GAP     = 3'd5,
    ST_FIN     = 3'd6
  } st_win_state;

  typedef struct packed {
    logic [8:0] x0;
    logic [8:0] x1;
    logic [8:0] y0;
    logic [8:0] y1;
  } win_t;

  // (x1-x0+1)*(y1-y0+1); only meaningful for a valid window
  function automatic logic [PIX_CNT_W-1:0] win_pix_count(input win_t w);
    logic [PIX_CNT_W-1:0] wd;
    logic [PIX_CNT_W-1:0] hd;
    wd = {8'd0, w.x1} - {8'd0, w.x0} + 17'd1;
    hd = {8'd0, w.y1} - {8'd0, w.y0} + 17'd1;
    return wd * hd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ili_window_writer_byte_sel.sv
`default_nettype none
// ============================================================================
//  Module      : ili_win_byte_sel
//  Description : Combinational selector returning byte and dc for window
//                byte index 0..10 (CASET + x range, PASET + y range, RAMWR).
//  Revision    : 1.0 - initial release
// ============================================================================
module ili_win_byte_sel
  import pkg_ili9341::*;
(
  input  logic [3:0] i_idx,
  input  win_t       i_win,
  output logic [7:0] o_data,
  output logic       o_dc
);

  // Coordinates are zero-extended to 16 bits and sent high byte first
  always_comb begin
    o_data = 8'h00;
    o_dc   = 1'b1;
    case (i_idx)
      4'd0:    begin o_data = CMD_CASET; o_dc = 1'b0; end
      4'd1:    o_data = {7'd0, i_win.x0[8]};
      4'd2:    o_data = i_win.x0[7:0];
      4'd3:    o_data = {7'd0, i_win.x1[8]};
      4'd4:    o_data = i_win.x1[7:0];
      4'd5:    begin o_data = CMD_PASET; o_dc = 1'b0; end
      4'd6:    o_data = {7'd0, i_win.y0[8]};
      4'd7:    o_data = i_win.y0[7:0];
      4'd8:    o_data = {7'd0, i_win.y1[8]};
      4'd9:    o_data = i_win.y1[7:0];
      4'd10:   begin o_data = CMD_RAMWR; o_dc = 1'b0; end
      default: begin o_data = 8'h00; o_dc = 1'b1; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ili_window_writer.sv
`default_nettype none
// ============================================================================
//  Module      : ili_window_writer
//  Description : Sequences an ILI9341 memory-window write (CASET, PASET,
//                RAMWR, RGB565 pixel stream) over a byte-level SPI path,
//                owning dc and cs for the whole transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module ili_window_writer
  import pkg_ili9341::*;
#(
  parameter int H_RES   = 240,
  parameter int V_RES   = 320,
  parameter int CS_IDLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [8:0]  i_x0,
  input  logic [8:0]  i_x1,
  input  logic [8:0]  i_y0,
  input  logic [8:0]  i_y1,
  input  logic        i_abort,
  input  logic        i_pix_valid,
  input  logic [15:0] i_pix_data,
  output logic        o_pix_ready,
  input  logic        i_byte_done,
  output logic        o_send,
  output logic [7:0]  o_data,
  output logic        o_dc,
  output logic        o_cs,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int          GAP_W     = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [GAP_W-1:0] c_gap_load = (CS_IDLE > 1) ? GAP_W'(CS_IDLE - 1) : '0;
  localparam logic [9:0]  c_h_res   = 10'(H_RES);
  localparam logic [9:0]  c_v_res   = 10'(V_RES);

  st_win_state          r_state;
  win_t                 r_win;
  logic [PIX_CNT_W-1:0] r_remaining;
  logic [3:0]           r_idx;
  logic                 r_in_pix;      // window bytes done, streaming pixels
  logic                 r_hi_pending;  // high byte sent, low byte still owed
  logic [7:0]           r_pix_lo;
  logic [GAP_W-1:0]     r_gap_cnt;

  win_t                 w_win_in;
  logic                 w_win_bad;
  logic [3:0]           w_sel_idx;
  logic [7:0]           w_sel_data;
  logic                 w_sel_dc;

  // Pack the request coordinates into the window tuple
  always_comb begin
    w_win_in = '{x0: i_x0, x1: i_x1, y0: i_y0, y1: i_y1};
  end

  // Reject reversed ranges and coordinates outside the panel
  always_comb begin
    w_win_bad = (r_win.x0 > r_win.x1) || (r_win.y0 > r_win.y1) ||
                ({1'b0, r_win.x1} >= c_h_res) || ({1'b0, r_win.y1} >= c_v_res);
  end

  // CHECK issues byte 0; WAIT issues the byte after the one just completed
  always_comb begin
    w_sel_idx = (r_state == ST_CHECK) ? 4'd0 : (r_idx + 4'd1);
  end

  ili_win_byte_sel u_byte_sel (
    .i_idx  (w_sel_idx),
    .i_win  (r_win),
    .o_data (w_sel_data),
    .o_dc   (w_sel_dc)
  );

  // Transaction FSM with registered SPI, handshake and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_win        <= '0;
      r_remaining  <= '0;
      r_idx        <= 4'd0;
      r_in_pix     <= 1'b0;
      r_hi_pending <= 1'b0;
      r_pix_lo     <= 8'h00;
      r_gap_cnt    <= '0;
      o_pix_ready  <= 1'b0;
      o_send       <= 1'b0;
      o_data       <= 8'h00;
      o_dc         <= 1'b0;
      o_cs         <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_send <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          o_busy <= 1'b0;
          // o_busy still high here only in the cycle after a rejected window
          if (i_start && !o_busy) begin
            r_win       <= w_win_in;
            r_remaining <= win_pix_count(w_win_in);
            o_busy      <= 1'b1;
            r_state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_win_bad) begin
            o_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            o_cs         <= 1'b0;
            o_send       <= 1'b1;
            o_data       <= w_sel_data;
            o_dc         <= w_sel_dc;
            r_idx        <= 4'd0;
            r_in_pix     <= 1'b0;
            r_hi_pending <= 1'b0;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_byte_done) begin
            if (r_hi_pending) begin
              // A started pixel always finishes, abort or not
              o_send       <= 1'b1;
              o_data       <= r_pix_lo;
              o_dc         <= 1'b1;
              r_hi_pending <= 1'b0;
              r_state      <= ST_SEND;
            end else if ((r_in_pix && (r_remaining == '0)) || i_abort) begin
              o_cs      <= 1'b1;
              r_gap_cnt <= c_gap_load;
              r_state   <= ST_GAP;
            end else if (r_in_pix || (r_idx == WIN_IDX_LAST)) begin
              r_in_pix    <= 1'b1;
              o_pix_ready <= 1'b1;
              r_state     <= ST_PIX_REQ;
            end else begin
              r_idx   <= r_idx + 4'd1;
              o_send  <= 1'b1;
              o_data  <= w_sel_data;
              o_dc    <= w_sel_dc;
              r_state <= ST_SEND;
            end
          end
        end
        ST_PIX_REQ: begin
          // o_pix_ready is high throughout this state, so valid completes
          // the handshake; an accepted pixel wins over a concurrent abort
          if (i_pix_valid) begin
            o_pix_ready  <= 1'b0;
            o_send       <= 1'b1;
            o_data       <= i_pix_data[15:8];
            o_dc         <= 1'b1;
            r_pix_lo     <= i_pix_data[7:0];
            r_hi_pending <= 1'b1;
            r_remaining  <= r_remaining - 17'd1;
            r_state      <= ST_SEND;
          end else if (i_abort) begin
            o_pix_ready <= 1'b0;
            o_cs        <= 1'b1;
            r_gap_cnt   <= c_gap_load;
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            o_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        ST_FIN: begin
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ili_window_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ili_window_writer
//  Description : Scoreboard bench for ili_window_writer. Expected bytes are
//                queued when a window is started; a monitor pops one entry
//                for every o_send and compares dc/data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ili_window_writer;

  localparam int BD_DELAY = 8;
  localparam int CS_IDLE  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_pix_valid, i_byte_done;
  logic [8:0]  i_x0, i_x1, i_y0, i_y1;
  logic [15:0] i_pix_data;
  logic        o_pix_ready, o_send, o_dc, o_cs, o_busy, o_done, o_err;
  logic [7:0]  o_data;

  logic [8:0] exp_q[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  int send_cnt = 0, done_cnt = 0, err_cnt = 0, ready_cyc = 0, acc_cnt = 0;
  int bd_cyc = 0, done_cyc = 0, bd_timer = 0;

  ili_window_writer #(.H_RES(240), .V_RES(320), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1),
    .i_abort(i_abort), .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
    .o_pix_ready(o_pix_ready), .i_byte_done(i_byte_done), .o_send(o_send),
    .o_data(o_data), .o_dc(o_dc), .o_cs(o_cs), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SPI controller model: byte_done BD_DELAY cycles after each send
  initial begin
    i_byte_done = 1'b0;
    forever begin
      @(negedge clk);
      i_byte_done = 1'b0;
      if (!rst) bd_timer = 0;
      else if (bd_timer > 0) begin
        bd_timer--;
        if (bd_timer == 0) begin
          i_byte_done = 1'b1;
          bd_cyc = cyc;
        end
      end else if (o_send) bd_timer = BD_DELAY;
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (o_pix_ready) ready_cyc++;
        if (o_pix_ready && i_pix_valid) acc_cnt++;
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_err) err_cnt++;
        if (o_send) begin
          send_cnt++;
          chk("cs_low_on_send", o_cs, 0);
          if (exp_q.size() == 0) chk("unexpected_byte", {o_dc, o_data}, 32'h1FF);
          else chk("byte", {23'd0, o_dc, o_data}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // v holds the 11 window bytes, byte 0 in the top byte
  task automatic push_win(input logic [87:0] v);
    logic [7:0] b;
    for (int i = 0; i < 11; i++) begin
      b = v[87-8*i -: 8];
      exp_q.push_back({((i != 0) && (i != 5) && (i != 10)), b});
    end
  endtask

  task automatic push_px(input logic [15:0] px);
    exp_q.push_back({1'b1, px[15:8]});
    exp_q.push_back({1'b1, px[7:0]});
  endtask

  task automatic start_win(input logic [8:0] x0, x1, y0, y1);
    @(negedge clk);
    i_x0 = x0; i_x1 = x1; i_y0 = y0; i_y1 = y1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic feed_px(input logic [15:0] px, input int gap, input bit cs_chk);
    bit ok;
    repeat (gap) @(negedge clk);
    if (cs_chk) begin
      chk("cs_low_while_stalled", o_cs, 0);
      chk("ready_while_stalled", o_pix_ready, 1);
    end
    #1;
    i_pix_valid = 1'b1;
    i_pix_data  = px;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (o_pix_ready) begin ok = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    i_pix_valid = 1'b0;
    chk("px_accept_timeout", ok, 1);
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
    chk("done_timeout", ok, 1);
  endtask

  task automatic err_case(input logic [8:0] x0, x1, y0, y1);
    int s0, e0;
    s0 = send_cnt; e0 = err_cnt;
    start_win(x0, x1, y0, y1);                      // now in T+1
    chk("err_busy_t1", o_busy, 1);
    chk("err_err_t1", o_err, 0);
    @(negedge clk);                                 // T+2
    chk("err_pulse_t2", o_err, 1);
    chk("err_cs_t2", o_cs, 1);
    @(negedge clk);                                 // T+3
    chk("err_busy_t3", o_busy, 0);
    chk("err_pulse_len", o_err, 0);
    repeat (5) @(negedge clk);
    chk("err_no_send", send_cnt - s0, 0);
    chk("err_count", err_cnt - e0, 1);
  endtask

  initial begin
    int d0, s0, a0;
    rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_pix_valid = 1'b0;
    i_pix_data = 16'h0; i_x0 = 0; i_x1 = 0; i_y0 = 0; i_y1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs", o_cs, 1);
    chk("rst_send", o_send, 0);
    chk("rst_data", o_data, 0);
    chk("rst_dc", o_dc, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ready", o_pix_ready, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Full panel window, two pixels then abort
    push_win(88'h2A_0000_00EF_2B_0000_013F_2C);
    push_px(16'h1234);
    push_px(16'hABCD);
    start_win(9'd0, 9'd239, 9'd0, 9'd319);
    feed_px(16'h1234, 0, 1'b0);
    feed_px(16'hABCD, 0, 1'b0);
    i_abort = 1'b1;
    wait_done(1);
    i_abort = 1'b0;
    chk("A_cs_high_at_done", o_cs, 1);
    chk("A_queue_empty", exp_q.size(), 0);
    chk("A_no_err", err_cnt, 0);
    chk("A_sends", send_cnt, 15);

    // 1x1 window with valid held high
    s0 = send_cnt; ready_cyc = 0; acc_cnt = 0;
    push_win(88'h2A_000A_000A_2B_0014_0014_2C);
    push_px(16'hF800);
    i_pix_valid = 1'b1; i_pix_data = 16'hF800;
    start_win(9'd10, 9'd10, 9'd20, 9'd20);
    wait_done(2);
    i_pix_valid = 1'b0;
    chk("B_sends", send_cnt - s0, 13);
    chk("B_done_latency", done_cyc - bd_cyc, 1 + CS_IDLE);
    chk("B_ready_cycles", ready_cyc, 1);
    chk("B_accepts", acc_cnt, 1);
    chk("B_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("B_busy_low", o_busy, 0);

    // Invalid windows
    err_case(9'd5, 9'd3, 9'd0, 9'd0);
    err_case(9'd0, 9'd240, 9'd0, 9'd0);

    // Stalled pixel source, cs stays low
    s0 = send_cnt;
    push_win(88'h2A_0000_0001_2B_0000_0000_2C);
    push_px(16'hA55A);
    push_px(16'h0F0F);
    start_win(9'd0, 9'd1, 9'd0, 9'd0);
    feed_px(16'hA55A, 150, 1'b1);
    feed_px(16'h0F0F, 50 + 20, 1'b1);
    wait_done(3);
    chk("D_sends", send_cnt - s0, 15);
    chk("D_done_once", done_cnt, 3);
    chk("D_queue_empty", exp_q.size(), 0);

    // 4x4 window, abort right after pixel 3 high byte
    s0 = send_cnt; acc_cnt = 0;
    push_win(88'h2A_0000_0003_2B_0000_0003_2C);
    push_px(16'h1111);
    push_px(16'h2222);
    push_px(16'h3333);
    start_win(9'd0, 9'd3, 9'd0, 9'd3);
    feed_px(16'h1111, 0, 1'b0);
    feed_px(16'h2222, 0, 1'b0);
    feed_px(16'h3333, 0, 1'b0);
    @(negedge clk);
    chk("E_hi3_sent", send_cnt - s0, 16);
    #1;
    i_abort = 1'b1;
    i_pix_valid = 1'b1; i_pix_data = 16'h4444;
    wait_done(4);
    i_abort = 1'b0; i_pix_valid = 1'b0;
    chk("E_sends", send_cnt - s0, 17);
    chk("E_accepts", acc_cnt, 3);
    chk("E_no_err", err_cnt, 2);
    chk("E_queue_empty", exp_q.size(), 0);

    // Reset while waiting on a byte
    s0 = send_cnt; d0 = done_cnt;
    push_win(88'h2A_0000_0000_2B_0000_0000_2C);
    start_win(9'd0, 9'd0, 9'd0, 9'd0);
    a0 = 0;
    for (int k = 0; k < 200 && (send_cnt - s0) < 2; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("F_in_wait", send_cnt - s0, 2);
    rst = 1'b0;
    #1;
    chk("F_rst_cs", o_cs, 1);
    chk("F_rst_send", o_send, 0);
    chk("F_rst_data", o_data, 0);
    chk("F_rst_dc", o_dc, 0);
    chk("F_rst_busy", o_busy, 0);
    chk("F_rst_ready", o_pix_ready, 0);
    chk("F_rst_done", o_done, 0);
    exp_q.delete();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    s0 = send_cnt;
    push_win(88'h2A_00EF_00EF_2B_013F_013F_2C);
    push_px(16'h07E0);
    i_pix_valid = 1'b1; i_pix_data = 16'h07E0;
    start_win(9'd239, 9'd239, 9'd319, 9'd319);
    wait_done(d0 + 1);
    i_pix_valid = 1'b0;
    chk("F_sends", send_cnt - s0, 13);
    chk("F_queue_empty", exp_q.size(), 0);
    chk("F_no_err", err_cnt, 2 + a0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
